// File: rtl/ttl652_registered_transceiver.sv
// WIDTH-bit registered bidirectional transceiver (74x652 style). A clocked
// direction controller holds both buses released for a dead-time on every reversal.
module ttl652_registered_transceiver #(
  parameter int WIDTH             = 8,
  parameter int TURNAROUND_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] A,
  inout  wire  [WIDTH-1:0] B,
  input  logic             DIR,
  input  logic             OE_n,
  input  logic             CAB,
  input  logic             CBA,
  input  logic             SAB,
  input  logic             SBA,
  output logic             drive_a,
  output logic             drive_b,
  output logic             turning
);

  // state   | meaning
  // IDLE    | neither bus driven, waiting for an enable request
  // DRIVE_B | A-to-B: B driven from live A or reg_a
  // DRIVE_A | B-to-A: A driven from live B or reg_b
  // TURN    | dead-time after a reversal, both buses released
  typedef enum logic [1:0] {IDLE, DRIVE_B, DRIVE_A, TURN} state_t;

  localparam bit         NO_TURN   = (TURNAROUND_CYCLES == 0);
  localparam logic [3:0] TURN_LOAD = NO_TURN ? 4'd0 : 4'(TURNAROUND_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] reg_a_q, reg_b_q;

  logic req_off, req_ab, req_ba;

  assign req_off = OE_n;
  assign req_ab  = !OE_n && DIR;
  assign req_ba  = !OE_n && !DIR;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Capture is state-independent, so the block may store what it drives.
      if (CAB) reg_a_q <= A;
      if (CBA) reg_b_q <= B;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_ab)      state_d = DRIVE_B;
        else if (req_ba) state_d = DRIVE_A;
      end
      DRIVE_B: begin
        if (req_off) begin
          state_d = IDLE;
        end else if (req_ba) begin
          if (NO_TURN) begin
            state_d = DRIVE_A;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      DRIVE_A: begin
        if (req_off) begin
          state_d = IDLE;
        end else if (req_ab) begin
          if (NO_TURN) begin
            state_d = DRIVE_B;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN: begin
        // A request flip here does not reload the counter.
        if (req_off)            state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = req_ab ? DRIVE_B : DRIVE_A;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign drive_b = (state_q == DRIVE_B);
  assign drive_a = (state_q == DRIVE_A);
  assign turning = (state_q == TURN);

  assign B = drive_b ? (SAB ? reg_a_q : A) : {WIDTH{1'bz}};
  assign A = drive_a ? (SBA ? reg_b_q : B) : {WIDTH{1'bz}};

endmodule

// File: doc/ttl652_registered_transceiver.md
Name: ttl652_registered_transceiver

Overview:
- Parametrised successor to the octal bus transceiver: a WIDTH-bit bidirectional transceiver with per-direction storage registers, in the style of the 74x652.
- Adds a clocked direction/enable controller that inserts a programmable dead-time (both sides high-Z) on every direction reversal, preventing bus contention between board-level buses.
- Sits between two shared TTL-style buses in the machine, for example the store data bus and the accumulator/CI bus.

Parameters:
- WIDTH, 8, bus width in bits (>=1).
- TURNAROUND_CYCLES, 1, high-Z dead cycles inserted on a direction reversal (0..15; 0 = immediate swap).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- A  inout  WIDTH  A-side bus.
- B  inout  WIDTH  B-side bus.
- DIR  input  1  requested direction: 1 = A to B, 0 = B to A.
- OE_n  input  1  output enable request, active low.
- CAB  input  1  capture enable: store A into reg_a at the rising edge.
- CBA  input  1  capture enable: store B into reg_b at the rising edge.
- SAB  input  1  B source select: 0 = live A, 1 = reg_a.
- SBA  input  1  A source select: 0 = live B, 1 = reg_b.
- drive_a  output  1  high while the block drives A.
- drive_b  output  1  high while the block drives B.
- turning  output  1  high during the dead-time state.

Behaviour:
- Reset is synchronous, active-low: reset_n=0 sampled at the rising edge has priority over everything.
  - State -> IDLE, reg_a=reg_b=0, turn counter=0.
  - drive_a=drive_b=turning=0; A and B high-Z.
  - This applies mid-operation too: both buses release after that edge.
- Request decode, each edge:
  - OFF if OE_n=1.
  - AB if OE_n=0 and DIR=1.
  - BA if OE_n=0 and DIR=0.
- States are IDLE, DRIVE_B, DRIVE_A and TURN. The state is registered; all bus enables decode from the registered state only.
- IDLE (no drive):
  - AB -> DRIVE_B.
  - BA -> DRIVE_A.
  - OFF -> stay.
- DRIVE_B (drive_b=1; B = SAB ? reg_a : A):
  - OFF -> IDLE.
  - BA -> TURN with counter=TURNAROUND_CYCLES-1, or straight to DRIVE_A if TURNAROUND_CYCLES=0.
  - AB -> stay.
- DRIVE_A (drive_a=1; A = SBA ? reg_b : B): mirror of DRIVE_B.
  - OFF -> IDLE.
  - AB -> TURN, or straight to DRIVE_B if TURNAROUND_CYCLES=0.
  - BA -> stay.
- TURN (turning=1; neither bus driven):
  - OFF at any edge -> IDLE.
  - Otherwise, if counter=0, go to the state matching the current request (AB -> DRIVE_B, BA -> DRIVE_A); else decrement the counter.
  - A request flip during TURN does not restart the counter.
- Latency:
  - Enable and direction changes take effect one edge after they are sampled.
  - A reversal takes 1+TURNAROUND_CYCLES edges to drive the new side.
- Data path:
  - Live data (SAB=0 / SBA=0) is combinational, with no clock latency.
  - Select changes are combinational.
- Storage:
  - reg_a <= A at an edge where CAB=1; reg_b <= B at an edge where CBA=1.
  - Capture is independent of state, including capturing a value the block itself is driving.
  - A captured high-Z bus stores X; this is legal and not flagged.
  - CAB and CBA may both be asserted in the same cycle; both capture.
- drive_a and drive_b are never both 1. Neither bus is ever driven in IDLE or TURN.

Test Plan:
- Reset, then OE_n=0, DIR=1, A=8'hAA, SAB=0 -> after 1 edge: drive_b=1 and B=8'hAA. Change A to 8'hF0 -> B=8'hF0 with no edge needed.
- From DRIVE_B, set DIR=0 and drive B externally with 8'h3C:
  - Edge 1: turning=1, A and B both not driven by the block.
  - Edge 2: drive_a=1 and A=8'h3C.
  - With TURNAROUND_CYCLES=3: drive_a asserts at edge 4.
- Register mode: A=8'h55, CAB=1 for one edge. Then A=8'h00 and SAB=1 in DRIVE_B -> B=8'h55 (stored), not 8'h00.
- OE_n=1 from DRIVE_A -> after 1 edge: A===8'hzz, drive_a=0. Repeat from TURN -> IDLE at the next edge.
- reset_n=0 for one edge while in DRIVE_B with reg_a=8'hC3 -> both buses high-Z after the edge and reg_a=0 (check via SAB=1 after re-enable: B=8'h00).
- Contention check: toggle DIR every cycle for 20 cycles with OE_n=0 -> drive_a&drive_b is never 1, and turning is asserted between every pair of opposite drive periods.
